spike_rate_encoder: RTL and testbench
=====================================

SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of encoder channels, one per input neuron.
REQ-002 SHALL have parameter SAMPLE_W, default 8: sample width per channel.
REQ-003 SHALL have parameter WINDOW, default 16: encode window length in cycles, legal range 1..255.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port s_valid, input, 1: sample frame offered.
REQ-007 SHALL have port s_ready, output, 1: frame can be accepted.
REQ-008 SHALL have port s_data, input, NUM_CH*SAMPLE_W: channel i at bits [i*SAMPLE_W +: SAMPLE_W].
REQ-009 SHALL have port enc_spikes, output, NUM_CH: spike vector to the SNN input layer.
REQ-010 SHALL have port enc_current, output, NUM_CH*SAMPLE_W: per-channel current, same packing as s_data.
REQ-011 SHALL have port enc_valid, output, 1: high during every encode cycle.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on the last cycle of each window.
REQ-013 SHALL have port frame_cnt, output, 16: count of completed frames, wraps at 65535 to 0.
REQ-014 SHALL have port window_spikes, output, 16: total spikes emitted in the last completed window.

Function
REQ-015 SHALL transfer a frame on any rising edge where s_valid and s_ready are both high; s_data is latched at that edge.
REQ-016 SHALL hold one active frame and one pending frame; s_ready = !pending_valid.
REQ-017 SHALL implement states IDLE and ENCODE. IDLE with a frame accepted goes to ENCODE; ENCODE on its last window cycle goes to ENCODE if a frame is pending (promote it, no gap) and to IDLE otherwise.
REQ-018 SHALL assert enc_valid for exactly WINDOW consecutive cycles per frame; the first cycle is the cycle after acceptance in IDLE.
REQ-019 SHALL promote a frame accepted in the same edge as a window's last cycle directly to active, so back-to-back frames have no gap.
REQ-020 SHALL clear each channel's 9-bit accumulator when a frame becomes active.
REQ-021 SHALL, on each encode cycle, compute acc_i = acc_i[7:0] + sample_i and set spike_i = carry bit 8; spike rate is sample/256 per cycle (deterministic mode).
REQ-022 SHALL drive enc_current[i] = sample_i when spike_i = 1, else 0; enc_spikes and enc_current are registered.
REQ-023 SHALL drive enc_spikes = 0, enc_current = 0 and enc_valid = 0 outside ENCODE.
REQ-024 SHALL accumulate the popcount of enc_spikes across the window in a saturating 16-bit counter; the count moves to window_spikes on the done cycle and the counter clears.
REQ-025 SHALL increment frame_cnt on each done pulse.
REQ-026 SHALL treat sample 0 as never spiking and sample 255 as spiking on WINDOW-1 of WINDOW cycles.

Reset
REQ-027 SHALL, while rst is high, force all outputs to 0 (s_ready = 1 once rst is released), set state to IDLE and discard active and pending frames, including mid-window.
REQ-028 SHALL make the first acceptance after reset release take effect at the first clock edge with s_valid high.

Configuration
REQ-029 SHALL use macro SPIKE_ENC_POISSON_EN to select the encoding mode.
- Defined: spike_i = (sample_i > rnd_i), where rnd_i is an 8-bit slice of a 16-bit Fibonacci LFSR. Taps 16,14,13,11; seed 16'hACE1 on reset; advances every encode cycle; slice i is rotated by i bits.
- Undefined: accumulator mode per REQ-021; no LFSR is instantiated.
- Both modes: sample 0 never spikes; handshake and timing are identical.

Structure
REQ-030 SHALL place in shared package spike_enc_pkg: the state enum (IDLE, ENCODE), the LFSR seed and tap constants, and default NUM_CH/SAMPLE_W/WINDOW.
REQ-031 SHALL isolate the LFSR in sub-module spike_lfsr16, instantiated only under SPIKE_ENC_POISSON_EN.

Verification
REQ-032 SHALL cover: deterministic mode, WINDOW=16, all channels 128 -> 8 spikes per channel, window_spikes=64, done on cycle 16, frame_cnt=1.
REQ-033 SHALL cover: channel 0=255, others 0 -> channel 0 spikes 15 of 16 cycles, enc_current[0]=255 on spike cycles, other channels silent, window_spikes=15.
REQ-034 SHALL cover: s_valid held high for 3 frames -> 48 contiguous enc_valid cycles, s_ready low while pending is full, frame_cnt=3.
REQ-035 SHALL cover: rst asserted on encode cycle 7 -> all outputs 0 in the same cycle, pending frame dropped, frame_cnt=0, s_ready=1 after release.
REQ-036 SHALL cover: Poisson mode with all samples 0 -> zero spikes; all samples 200 -> per-channel count over 16 windows within 200/256 +/- 10%.

Source files
------------

// File: rtl/spike_enc_pkg.sv
// rtl/spike_enc_pkg.sv - shared state type, LFSR constants and default sizes for the spike rate encoder
package spike_enc_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ENCODE = 1'b1
  } enc_state_t;

  localparam int DEF_NUM_CH   = 8;
  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_WINDOW   = 16;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Rotate the LFSR state right by sh bits and keep the low byte
  function automatic logic [7:0] rot_slice(input logic [15:0] v, input int unsigned sh);
    logic [31:0] d;
    d = {v, v} >> (sh % 16);
    return d[7:0];
  endfunction

endpackage

// File: rtl/spike_lfsr16.sv
// rtl/spike_lfsr16.sv - 16-bit Fibonacci LFSR random source for Poisson-mode encoding
module spike_lfsr16
  import spike_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  // Shift left and feed the XOR of the tapped bits into bit 0 on every enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= LFSR_SEED;
    end else if (en) begin
      value <= {value[14:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// rtl/spike_rate_encoder.sv - rate-codes sample frames into spike trains; SPIKE_ENC_POISSON_EN selects Poisson mode
module spike_rate_encoder
  import spike_enc_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int WINDOW   = DEF_WINDOW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0]   s_data,
  output logic [NUM_CH-1:0]            enc_spikes,
  output logic [NUM_CH*SAMPLE_W-1:0]   enc_current,
  output logic                         enc_valid,
  output logic                         done,
  output logic [15:0]                  frame_cnt,
  output logic [15:0]                  window_spikes
);

  localparam int          FW       = NUM_CH * SAMPLE_W;
  localparam logic [7:0]  LAST_IDX = 8'(WINDOW - 1);

  enc_state_t          state;
  logic [FW-1:0]       active_data;
  logic [FW-1:0]       pending_data;
  logic                pending_valid;
  logic [7:0]          win_cnt;
  logic [15:0]         spike_cnt;

  logic                last;
  logic                accept;
  logic                load_new;
  logic                enc_next;
  logic [FW-1:0]       cur_frame;
  logic [7:0]          win_next;
  logic [NUM_CH-1:0]   spk_next;
  logic [FW-1:0]       cur_next;
  logic [16:0]         cnt_sum;
  logic [15:0]         cnt_sat;

  // Frame slots: s_ready drops while the pending slot is occupied and during reset
  assign s_ready  = !pending_valid && !rst;
  assign accept   = s_valid && s_ready;
  assign last     = (state == ENCODE) && (win_cnt == LAST_IDX);
  // A frame becomes active from IDLE, or at a window end from pending or a same-edge offer
  assign load_new = ((state == IDLE) && accept) || (last && (pending_valid || accept));
  assign enc_next = load_new || ((state == ENCODE) && !last);
  assign cur_frame = load_new ? (pending_valid ? pending_data : s_data) : active_data;
  assign win_next  = load_new ? 8'd0 : win_cnt + 8'd1;

`ifdef SPIKE_ENC_POISSON_EN
  logic [15:0] lfsr_value;

  spike_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (enc_next),
    .value (lfsr_value)
  );

  // Each channel spikes when its sample beats its own rotated slice of the LFSR
  always_comb begin
    logic [SAMPLE_W-1:0] smp;
    logic [7:0]          rnd;
    smp      = '0;
    rnd      = '0;
    spk_next = '0;
    cur_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      smp = cur_frame[i*SAMPLE_W +: SAMPLE_W];
      rnd = rot_slice(lfsr_value, i);
      spk_next[i] = {8'd0, smp} > {{SAMPLE_W{1'b0}}, rnd};
      cur_next[i*SAMPLE_W +: SAMPLE_W] = spk_next[i] ? smp : '0;
    end
  end
`else
  logic [FW-1:0] acc;
  logic [FW-1:0] acc_next;

  // Per-channel phase accumulator; the carry out of the add is the spike
  always_comb begin
    logic [SAMPLE_W-1:0] smp;
    logic [SAMPLE_W-1:0] base;
    logic [SAMPLE_W:0]   sum;
    smp      = '0;
    base     = '0;
    sum      = '0;
    spk_next = '0;
    cur_next = '0;
    acc_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      smp  = cur_frame[i*SAMPLE_W +: SAMPLE_W];
      base = load_new ? '0 : acc[i*SAMPLE_W +: SAMPLE_W];
      sum  = {1'b0, base} + {1'b0, smp};
      acc_next[i*SAMPLE_W +: SAMPLE_W] = sum[SAMPLE_W-1:0];
      spk_next[i] = sum[SAMPLE_W];
      cur_next[i*SAMPLE_W +: SAMPLE_W] = sum[SAMPLE_W] ? smp : '0;
    end
  end

  // Accumulator state advances with every encode cycle and restarts on each new frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (enc_next) begin
      acc <= acc_next;
    end
  end
`endif

  // Encoder FSM with registered spike, current, valid and done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      active_data   <= '0;
      pending_data  <= '0;
      pending_valid <= 1'b0;
      win_cnt       <= '0;
      enc_spikes    <= '0;
      enc_current   <= '0;
      enc_valid     <= 1'b0;
      done          <= 1'b0;
    end else begin
      state     <= enc_next ? ENCODE : IDLE;
      enc_valid <= enc_next;
      if (enc_next) begin
        active_data <= cur_frame;
        win_cnt     <= win_next;
        enc_spikes  <= spk_next;
        enc_current <= cur_next;
        done        <= (win_next == LAST_IDX);
      end else begin
        win_cnt     <= '0;
        enc_spikes  <= '0;
        enc_current <= '0;
        done        <= 1'b0;
      end
      if (last && pending_valid) begin
        pending_valid <= 1'b0;
      end else if ((state == ENCODE) && !last && accept) begin
        pending_data  <= s_data;
        pending_valid <= 1'b1;
      end
    end
  end

  assign cnt_sum = {1'b0, spike_cnt} + 17'($countones(enc_spikes));
  assign cnt_sat = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  // Window statistics: saturating spike total published and frame counted at each window end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_cnt     <= '0;
      window_spikes <= '0;
      frame_cnt     <= '0;
    end else if (done) begin
      window_spikes <= cnt_sat;
      spike_cnt     <= '0;
      frame_cnt     <= frame_cnt + 16'd1;
    end else if (enc_valid) begin
      spike_cnt <= cnt_sat;
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb/tb_spike_rate_encoder.sv - directed table-driven bench for spike_rate_encoder
module tb_spike_rate_encoder;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic [7:0]  enc_spikes;
  logic [63:0] enc_current;
  logic        enc_valid;
  logic        done;
  logic [15:0] frame_cnt;
  logic [15:0] window_spikes;

  int n_checks = 0;
  int n_fail   = 0;

  spike_rate_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .enc_spikes    (enc_spikes),
    .enc_current   (enc_current),
    .enc_valid     (enc_valid),
    .done          (done),
    .frame_cnt     (frame_cnt),
    .window_spikes (window_spikes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [31:0] exp_cnt;
    int          exp_total;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one frame from idle and observe its whole window
  task automatic run_frame(input logic [63:0] data, output int cyc, output int done_at,
                           output logic [63:0] cnts, output int cur_err);
    logic [7:0] expc;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = data;
    check("s_ready_idle", {63'd0, s_ready}, 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    cyc = 0; done_at = 0; cnts = '0; cur_err = 0;
    for (int t = 0; t < 40; t++) begin
      if (enc_valid) begin
        cyc++;
        if (done) done_at = cyc;
        for (int ch = 0; ch < 8; ch++) begin
          if (enc_spikes[ch]) cnts[ch*8 +: 8] += 8'd1;
          expc = enc_spikes[ch] ? data[ch*8 +: 8] : 8'd0;
          if (enc_current[ch*8 +: 8] !== expc) cur_err++;
        end
      end else if (cyc > 0) begin
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int          cyc, done_at, cur_err, en_cnt, first, lastc, ready_low, dones, acc_n, fc0;
    logic [63:0] cnts;
    logic [63:0] data;
    logic [31:0] ecnt;

    vecs[0] = '{64'h8080808080808080, 32'h88888888, 64};
    vecs[1] = '{64'h00000000000000FF, 32'h0000000F, 15};
    vecs[2] = '{64'h0000000000000000, 32'h00000000, 0};
    vecs[3] = '{64'h1010101010101010, 32'h11111111, 8};
    vecs[4] = '{64'hE0C0A08060402000, 32'hECA86420, 56};
    vecs[5] = '{64'hFFFFFFFFFFFFFF01, 32'hFFFFFFF0, 105};

    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_enc_valid", {63'd0, enc_valid}, 64'd0);
    check("rst_enc_spikes", {56'd0, enc_spikes}, 64'd0);
    check("rst_enc_current", enc_current, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    check("rst_window_spikes", {48'd0, window_spikes}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_s_ready", {63'd0, s_ready}, 64'd1);

`ifndef SPIKE_ENC_POISSON_EN
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].data, cyc, done_at, cnts, cur_err);
      ecnt = vecs[v].exp_cnt;
      check($sformatf("v%0d_enc_cycles", v), 64'(cyc), 64'd16);
      check($sformatf("v%0d_done_at", v), 64'(done_at), 64'd16);
      for (int ch = 0; ch < 8; ch++)
        check($sformatf("v%0d_ch%0d_spikes", v, ch), {56'd0, cnts[ch*8 +: 8]}, {60'd0, ecnt[ch*4 +: 4]});
      check($sformatf("v%0d_current", v), 64'(cur_err), 64'd0);
      check($sformatf("v%0d_window_spikes", v), {48'd0, window_spikes}, 64'(vecs[v].exp_total));
      check($sformatf("v%0d_frame_cnt", v), {48'd0, frame_cnt}, 64'(v + 1));
      check($sformatf("v%0d_idle_outputs", v), {enc_current[55:0], enc_spikes}, 64'd0);
    end
`else
    run_frame(64'd0, cyc, done_at, cnts, cur_err);
    check("p0_enc_cycles", 64'(cyc), 64'd16);
    check("p0_spikes", cnts, 64'd0);
    check("p0_window_spikes", {48'd0, window_spikes}, 64'd0);
    begin
      int tot [8];
      for (int ch = 0; ch < 8; ch++) tot[ch] = 0;
      for (int f = 0; f < 16; f++) begin
        run_frame({8{8'd200}}, cyc, done_at, cnts, cur_err);
        for (int ch = 0; ch < 8; ch++) tot[ch] += int'(cnts[ch*8 +: 8]);
      end
      for (int ch = 0; ch < 8; ch++)
        check($sformatf("p200_ch%0d_in_range_%0d", ch, tot[ch]),
              {63'd0, (tot[ch] >= 180 && tot[ch] <= 220)}, 64'd1);
    end
`endif

    // Frame offered on the last cycle of a window is promoted with no gap
    fc0 = int'(frame_cnt);
    en_cnt = 0; first = -1; lastc = -1; acc_n = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (enc_valid) begin en_cnt++; if (first < 0) first = t; lastc = t; end
      s_valid = 1'b0;
      if (t == 0 || (done && acc_n == 1)) begin
        if (done) check("promo_s_ready_last", {63'd0, s_ready}, 64'd1);
        s_valid = 1'b1;
        s_data  = {8{8'h10}};
        if (s_ready) acc_n++;
      end
    end
    s_valid = 1'b0;
    check("promo_enc_cycles", 64'(en_cnt), 64'd32);
    check("promo_contiguous", 64'(lastc - first + 1), 64'd32);
    check("promo_frames", 64'(int'(frame_cnt) - fc0), 64'd2);
`ifndef SPIKE_ENC_POISSON_EN
    check("promo_window_spikes", {48'd0, window_spikes}, 64'd8);
`endif

    // s_valid held high for three frames: 48 contiguous encode cycles
    fc0 = int'(frame_cnt);
    en_cnt = 0; first = -1; lastc = -1; ready_low = 0; dones = 0; acc_n = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (enc_valid) begin en_cnt++; if (first < 0) first = t; lastc = t; end
      if (done) dones++;
      if (!s_ready) ready_low++;
      s_valid = (acc_n < 3);
      s_data  = {8{8'h80}};
      if (s_valid && s_ready) acc_n++;
    end
    s_valid = 1'b0;
    check("b2b_enc_cycles", 64'(en_cnt), 64'd48);
    check("b2b_first", 64'(first), 64'd1);
    check("b2b_contiguous", 64'(lastc - first + 1), 64'd48);
    check("b2b_ready_low", 64'(ready_low), 64'd30);
    check("b2b_dones", 64'(dones), 64'd3);
    check("b2b_frames", 64'(int'(frame_cnt) - fc0), 64'd3);
`ifndef SPIKE_ENC_POISSON_EN
    check("b2b_window_spikes", {48'd0, window_spikes}, 64'd64);
`endif

    // Reset asserted on encode cycle 7 with a pending frame queued
    @(negedge clk);
    s_valid = 1'b1; s_data = {8{8'h80}};
    @(negedge clk);
    check("mid_pending_accept", {63'd0, s_ready}, 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_cycle7_valid", {63'd0, enc_valid}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_enc_valid", {63'd0, enc_valid}, 64'd0);
    check("mid_enc_spikes", {56'd0, enc_spikes}, 64'd0);
    check("mid_enc_current", enc_current, 64'd0);
    check("mid_done", {63'd0, done}, 64'd0);
    check("mid_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    check("mid_window_spikes", {48'd0, window_spikes}, 64'd0);
    check("mid_s_ready_in_rst", {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_s_ready_rel", {63'd0, s_ready}, 64'd1);
    en_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (enc_valid) en_cnt++;
    end
    check("mid_pending_dropped", 64'(en_cnt), 64'd0);
    check("mid_frame_cnt_after", {48'd0, frame_cnt}, 64'd0);

    // First frame after reset is taken at the first edge with s_valid high
    data = {8{8'h80}};
    run_frame(data, cyc, done_at, cnts, cur_err);
    check("post_enc_cycles", 64'(cyc), 64'd16);
    check("post_done_at", 64'(done_at), 64'd16);
    check("post_frame_cnt", {48'd0, frame_cnt}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
